aes_round_sequencer: RTL

Iterative AES controller that sequences one shared single-round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey, or the inverse set) over all rounds of one 128-bit block. It accepts a block and a direction over a valid/ready handshake and performs the initial AddRoundKey whitening itself. It addresses an external round-key store by index and returns the result over a second valid/ready handshake. It sits between the block interface and the round datapath plus key-schedule storage.

---
 rtl/aes_round_sequencer.sv | 87 ++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES controller sequencing a shared single-round datapath over one 128-bit block
// Ports: in_valid/in_ready/in_data/in_decrypt accept a block; out_valid/out_ready/out_data return it;
// key_index/round_key address the external key store; dp_state/dp_decrypt/dp_final/dp_result drive
// the round datapath; busy and round_count report progress.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   key_index,
  input  logic [127:0] round_key,
  output logic [127:0] dp_state,
  output logic         dp_decrypt,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic         busy,
  output logic [3:0]   round_count
);
  if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
    $error("aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
  end
  localparam logic [3:0] NR = 4'(NUM_ROUNDS);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  fsm_t fsm, fsm_next;
  logic [127:0] state_reg, state_next;
  logic dir_reg, dir_next;
  logic [3:0] round_reg, round_next;
  logic in_round, last;
  assign in_round = fsm == ROUND;
  assign last = round_reg == NR;
  assign in_ready = fsm == IDLE;
  assign busy = fsm != IDLE;
  assign out_valid = fsm == DONE;
  assign out_data = out_valid ? state_reg : '0;
  assign dp_state = in_round ? state_reg : '0;
  assign dp_decrypt = in_round & dir_reg;
  assign dp_final = in_round & last;
  assign round_count = in_round ? round_reg : 4'd0;
  // In IDLE the index follows in_decrypt so the whitening key is present at acceptance;
  // decryption walks the schedule from Nr down to 0.
  assign key_index = in_ready ? (in_decrypt ? NR : 4'd0)
                   : in_round ? (dir_reg ? NR - round_reg : round_reg) : 4'd0;
  always_comb begin
    fsm_next = fsm;
    state_next = state_reg;
    dir_next = dir_reg;
    round_next = round_reg;
    case (fsm)
      IDLE: if (in_valid) begin
        fsm_next = ROUND;
        state_next = in_data ^ round_key;
        dir_next = in_decrypt;
        round_next = 4'd1;
      end
      ROUND: begin
        state_next = dp_result;
        fsm_next = last ? DONE : ROUND;
        round_next = last ? round_reg : round_reg + 4'd1;
      end
      DONE: if (out_ready) begin
        fsm_next = IDLE;
        round_next = 4'd0;
      end
      default: fsm_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm <= IDLE;
      state_reg <= '0;
      dir_reg <= 1'b0;
      round_reg <= 4'd0;
    end else begin
      fsm <= fsm_next;
      state_reg <= state_next;
      dir_reg <= dir_next;
      round_reg <= round_next;
    end
  end
endmodule
